// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  // addi x0,x0,0 -- the bubble presented while the queue is empty.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive sequential fetches.
  localparam logic [63:0] PC_STEP = 64'd4;

  // One queued fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Storage for the fetch queue: synchronous write, asynchronous read of the head.
// The read is combinational so the head reaches IF/ID without an extra cycle.
module fetch_fifo_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem [DEPTH];

  // Write the newly fetched entry into its slot; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-stage prefetch buffer: owns the fetch PC, issues sequential reads to
// instruction memory and queues {instr, pc} pairs for IF/ID. Decode stalls are
// absorbed by the queue; a branch flush empties it and redirects the fetch PC.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [63:0] IMEM_BYTES = 64'd256,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [63:0]              redirect_pc,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic         pop;
  logic         push;
  logic         fetch_ok;
  logic         not_full;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  assign out_valid = (count_reg != '0);
  assign fetch_ok  = (fetch_pc_reg < IMEM_BYTES);
  assign not_full  = (count_reg < CW'(DEPTH));
  // Flush suppresses both directions so wrong-path work never lands in the queue.
  assign pop       = out_valid & ~stall & ~flush;
  assign push      = fetch_ok & ~flush & (not_full | pop);

  assign wr_entry.instr = imem_instr;
  assign wr_entry.pc    = fetch_pc_reg;

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_entry)
  );

  // Next-state for pointers, occupancy and fetch PC; flush overrides everything.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (flush) begin
      fetch_pc_next = redirect_pc;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      // Pointers are a power-of-two width, so the increment wraps naturally.
      if (push) begin
        wr_ptr_next   = wr_ptr_reg + AW'(1);
        fetch_pc_next = fetch_pc_reg + PC_STEP;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  assign imem_addr = fetch_pc_reg;
  assign count     = count_reg;
  assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head_entry.pc    : 64'd0;

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch-stage prefetch buffer between program_counter/instruction_memory and the IF/ID register.
- Owns the fetch PC and issues sequential addresses to instruction memory. Buffers up to DEPTH {instruction, PC} pairs and presents the oldest pair to IF/ID.
- Decouples fetch from decode stalls (load-use hazard) and discards wrong-path entries on branch flush.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- RESET_PC, 64'd0, fetch PC after reset.
- IMEM_BYTES, 64'd256, instruction memory size in bytes; no fetch at or above this address.
- NOP_INSTR, 32'h0000_0013, instruction presented when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  1  1 = decode cannot accept (hazard unit); head is held.
- flush  in  1  1 = branch taken in MEM; discard all entries.
- redirect_pc  in  64  branch target; sampled when flush=1.
- imem_addr  out  64  address to instruction memory; equals fetch_pc.
- imem_instr  in  32  combinational instruction-memory read data for imem_addr.
- out_valid  out  1  head entry valid.
- out_instr  out  32  head instruction, or NOP_INSTR when out_valid=0.
- out_pc  out  64  head PC, or 64'd0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0.
  - Outputs: out_valid=0, out_instr=NOP_INSTR, out_pc=0, imem_addr=RESET_PC.
  - Storage contents need not be reset.
- Internal events:
  - pop = out_valid & ~stall & ~flush.
  - fetch_ok = (fetch_pc < IMEM_BYTES).
  - push = fetch_ok & ~flush & ((count < DEPTH) | pop).
- On push (rising edge):
  - mem[wr_ptr] <= {imem_instr, fetch_pc}.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - fetch_pc <= fetch_pc + 4.
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Full queue: push is allowed only when pop occurs in the same cycle. Otherwise fetch_pc holds and imem_addr is stable.
- Empty queue: out_valid=0 and the NOP bubble is presented. stall has no effect.
- Flush (highest priority; wins over push, pop and stall):
  - Next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc=redirect_pc.
  - The entry at imem_instr in the flush cycle is discarded.
  - The first target instruction appears at out_* one cycle after the flush edge.
- Latency:
  - Head outputs are combinational from the storage head (no output register).
  - An instruction pushed at edge N is visible at edge N+1.
  - Minimum fetch-to-out latency: 1 cycle.
- Stall:
  - While stall=1 and out_valid=1, out_instr and out_pc are stable.
  - Fetch continues until the queue is full.
- End of memory: once fetch_pc >= IMEM_BYTES, pushes stop. Entries already queued drain normally, then out_valid=0.
- Misaligned redirect_pc (bits [1:0] != 0) is accepted unchanged; handling it is the redirect source's responsibility.
- Reset asserted mid-operation: immediate return to the reset state, regardless of stall or flush.
- Arithmetic:
  - PC increment is 64-bit unsigned; overflow is not checked because it is bounded by IMEM_BYTES.
  - Pointers are $clog2(DEPTH) bits.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR localparam default.
  - PC_STEP = 64'd4.
  - Packed typedef fetch_entry_t {logic [31:0] instr; logic [63:0] pc}.
- One sub-module, fetch_fifo_mem: DEPTH x fetch_entry_t storage with synchronous write and asynchronous read at rd_ptr.
- Pointer, count and fetch_pc control stays in instr_fetch_queue.

Test Plan:
- Reset release, stall=0, imem returns addr-tagged words -> out_pc sequence 0,4,8,12 on consecutive cycles starting 1 cycle after release; count stays at 1.
- stall=1 for 6 cycles after out_pc=8 -> out_pc held at 8; count rises to 4 and saturates; imem_addr frozen at 24; release stall -> out_pc 12,16,20,24 with no gaps.
- Full queue (count=4) with stall=0 and push+pop each cycle -> count remains 4; the wr_ptr 3->0 wrap gives the correct PC order.
- flush=1, redirect_pc=64'h40, with 3 entries queued -> next cycle count=0, out_valid=0, out_instr=32'h0000_0013; the cycle after, out_pc=64'h40.
- flush=1 and stall=1 in the same cycle -> the flush is honoured (queue emptied, fetch_pc=redirect_pc).
- IMEM_BYTES=16 -> only PCs 0,4,8,12 emerge, then out_valid=0 permanently; reset=0 asserted mid-drain -> outputs return to reset values in the same cycle, asynchronously.
